gcd_requester: RTL and testbench



---
 rtl/gcd_requester.sv | 211 +++++++++++++++++++++
 tb/tb_gcd_requester.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// gcd_requester: initiator side of the gcd coprocessor req/ack handshake.
// Takes an operand pair on a valid/ready input port and performs the two-phase
// transfer: A is sent and acknowledged, then B is sent and the result
// acknowledge returns C. The result and a saturating latency count are then
// held on a valid/ready output port until the consumer takes them.
//
// Optional build macro: GCD_REQ_ZERO_BYPASS_EN
//   When defined, a pair with a zero operand skips the gcd block entirely and
//   is answered directly (gcd(x,0)=x, gcd(0,0)=0) with a cycle count of 0.
module gcd_requester #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [CNT_W-1:0]  out_cycles,
  output logic              busy,
  output logic              gcd_req,
  output logic [DATA_W-1:0] gcd_ab,
  input  logic              gcd_ack,
  input  logic [DATA_W-1:0] gcd_c
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A_REQ = 3'd1,
    ST_A_REL = 3'd2,
    ST_B_REQ = 3'd3,
    ST_B_REL = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [CNT_W-1:0]    cnt_r;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

`ifdef GCD_REQ_ZERO_BYPASS_EN
  // True when either operand is zero; such pairs never terminate in gcd.
  function automatic logic has_zero(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    return (a == {DATA_W{1'b0}}) || (b == {DATA_W{1'b0}});
  endfunction
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic for the four-phase handshake sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
`ifdef GCD_REQ_ZERO_BYPASS_EN
          if (has_zero(in_a, in_b)) begin
            state_nxt_s = ST_OUT;
          end else begin
            state_nxt_s = ST_A_REQ;
          end
`else
          state_nxt_s = ST_A_REQ;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_A_REQ: begin
        if (gcd_ack) begin
          state_nxt_s = ST_A_REL;
        end else begin
          state_nxt_s = ST_A_REQ;
        end
      end
      ST_A_REL: begin
        if (!gcd_ack) begin
          state_nxt_s = ST_B_REQ;
        end else begin
          state_nxt_s = ST_A_REL;
        end
      end
      ST_B_REQ: begin
        if (gcd_ack) begin
          state_nxt_s = ST_B_REL;
        end else begin
          state_nxt_s = ST_B_REQ;
        end
      end
      ST_B_REL: begin
        if (!gcd_ack) begin
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_B_REL;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded purely from the current state.
  always_comb begin
    in_ready  = 1'b0;
    gcd_req   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_A_REQ: gcd_req   = 1'b1;
      ST_B_REQ: gcd_req   = 1'b1;
      ST_OUT:   out_valid = 1'b1;
      default: begin
        gcd_req = 1'b0;
      end
    endcase
  end

  // Operand capture, AB bus drive, latency counter and result capture.
  // gcd_ab must keep A through A_REL because the gcd block reloads A on the
  // cycle req drops; it switches to B only on the move into B_REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r        <= {DATA_W{1'b0}};
      b_r        <= {DATA_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      gcd_ab     <= {DATA_W{1'b0}};
      out_c      <= {DATA_W{1'b0}};
      out_cycles <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            cnt_r <= {CNT_W{1'b0}};
`ifdef GCD_REQ_ZERO_BYPASS_EN
            if (has_zero(in_a, in_b)) begin
              out_c      <= in_a | in_b;
              out_cycles <= {CNT_W{1'b0}};
            end else begin
              gcd_ab <= in_a;
            end
`else
            gcd_ab <= in_a;
`endif
          end
        end
        ST_A_REQ: begin
          cnt_r  <= sat_inc(cnt_r);
          gcd_ab <= a_r;
        end
        ST_A_REL: begin
          cnt_r <= sat_inc(cnt_r);
          if (!gcd_ack) begin
            gcd_ab <= b_r;
          end else begin
            gcd_ab <= a_r;
          end
        end
        ST_B_REQ: begin
          cnt_r <= sat_inc(cnt_r);
          // gcd_c is only meaningful here while ack is high.
          if (gcd_ack) begin
            out_c      <= gcd_c;
            out_cycles <= sat_inc(cnt_r);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: a behavioural gcd responder drives
// the req/ack side, expected results come from plain Euclid arithmetic and
// the handshake phase-length sum.
module tb_gcd_requester;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_c;
  logic [CW-1:0] out_cycles;
  logic          busy;
  logic          gcd_req;
  logic [DW-1:0] gcd_ab;
  logic          gcd_ack;
  logic [DW-1:0] gcd_c;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // responder configuration (written by main flow) and observations
  int da_g = 0, dr_g = 0, db_g = 0;
  int rises;
  int rphase;
  logic [DW-1:0] cap_a, cap_b;

  gcd_requester #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_cycles(out_cycles), .busy(busy),
    .gcd_req(gcd_req), .gcd_ab(gcd_ab), .gcd_ack(gcd_ack), .gcd_c(gcd_c)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] x,
                                            input logic [DW-1:0] y);
    logic [DW-1:0] a, b, t;
    a = x;
    b = y;
    while (b != 16'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // latency = cycles spent in the A request, A release and B request phases
  function automatic logic [CW-1:0] ref_cyc(input int da, input int dr,
                                            input int db);
    int t;
    t = (1 + da) + (1 + dr) + (1 + db);
    if (t > 15) t = 15;
    return t[CW-1:0];
  endfunction

  // Behavioural gcd block: acks after programmable delays, evaluated on the
  // falling edge so its responses are stable at the next rising edge.
  initial begin
    int rcnt;
    logic prev;
    gcd_ack = 1'b0;
    gcd_c   = 16'hDEAD;
    rphase  = 0;
    rcnt    = 0;
    rises   = 0;
    prev    = 1'b0;
    cap_a   = 16'd0;
    cap_b   = 16'd0;
    forever begin
      @(negedge clk);
      if (gcd_req === 1'b1 && prev !== 1'b1) rises++;
      prev = gcd_req;
      if (reset) begin
        rphase = 0; rcnt = 0; gcd_ack = 1'b0; gcd_c = 16'hDEAD;
      end else begin
        case (rphase)
          0: if (gcd_req) begin
               if (rcnt >= da_g) begin gcd_ack = 1'b1; rphase = 1; rcnt = 0; end
               else rcnt++;
             end else rcnt = 0;
          1: if (!gcd_req) begin
               if (rcnt >= dr_g) begin
                 cap_a = gcd_ab; gcd_ack = 1'b0; rphase = 2; rcnt = 0;
               end else rcnt++;
             end
          2: if (gcd_req) begin
               if (rcnt >= db_g) begin
                 cap_b = gcd_ab; gcd_c = ref_gcd(cap_a, cap_b);
                 gcd_ack = 1'b1; rphase = 3; rcnt = 0;
               end else rcnt++;
             end
          3: if (!gcd_req) begin
               gcd_ack = 1'b0; gcd_c = 16'hDEAD; rphase = 0; rcnt = 0;
             end
          default: rphase = 0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // present a pair for one accept cycle (called at posedge+1 with in_ready=1)
  task automatic start(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input int da, input int dr, input int db);
    da_g = da; dr_g = dr; db_g = db;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_pair(input string nm, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int da, input int dr,
                          input int db, input logic [DW-1:0] exp_c,
                          input logic [CW-1:0] exp_cyc);
    int r0;
    r0 = rises;
    start(a, b, da, dr, db);
    chk({nm, "_in_ready_busy"}, in_ready, 1'b0);
    wait_out();
    chk({nm, "_c"}, out_c, exp_c);
    chk({nm, "_cycles"}, out_cycles, exp_cyc);
    chk({nm, "_ab_a"}, cap_a, a);
    chk({nm, "_ab_b"}, cap_b, b);
    chk({nm, "_req_rises"}, rises - r0, 2);
    release_out();
    chk({nm, "_idle"}, in_ready, 1'b1);
  endtask

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            da;
    int            dr;
    int            db;
    logic [DW-1:0] exp_c;
    logic [CW-1:0] exp_cyc;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int n;
    tbl[0] = '{16'd48,    16'd18,  0, 0, 3,  16'd6,   4'd6};
    tbl[1] = '{16'd7,     16'd7,   1, 1, 3,  16'd7,   4'd8};
    tbl[2] = '{16'd5,     16'd5,   0, 0, 0,  16'd5,   4'd3};
    tbl[3] = '{16'd12,    16'd8,   2, 0, 1,  16'd4,   4'd6};
    tbl[4] = '{16'd1,     16'd65535, 0, 0, 0, 16'd1,  4'd3};
    tbl[5] = '{16'd35,    16'd21,  3, 3, 12, 16'd7,   4'd15};
    tbl[6] = '{16'd65535, 16'd255, 0, 1, 0,  16'd255, 4'd4};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 16'd0; in_b = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gcd_req", gcd_req, 1'b0);
    chk("rst_gcd_ab", gcd_ab, 16'd0);
    chk("rst_out_c", out_c, 16'd0);
    chk("rst_out_cycles", out_cycles, 4'd0);

    for (int i = 0; i < 7; i++) begin
      run_pair($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].da,
               tbl[i].dr, tbl[i].db, tbl[i].exp_c, tbl[i].exp_cyc);
    end

    // backpressure: result held while out_ready is low
    start(16'd21, 16'd14, 0, 0, 1);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_c", out_c, 16'd7);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    release_out();
    chk("bp_after_valid", out_valid, 1'b0);
    chk("bp_after_idle", in_ready, 1'b1);
    chk("bp_after_busy", busy, 1'b0);

    // pair offered while busy is ignored, then re-presented in IDLE
    start(16'd9, 16'd6, 1, 1, 2);
    in_a = 16'd100; in_b = 16'd75; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ign_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_out();
    chk("ign_c", out_c, 16'd3);
    chk("ign_cycles", out_cycles, ref_cyc(1, 1, 2));
    chk("ign_ab_a", cap_a, 16'd9);
    release_out();
    run_pair("ign_retry", 16'd100, 16'd75, 0, 0, 2, 16'd25, ref_cyc(0, 0, 2));

    // reset while in B_REQ discards the transaction
    start(16'd30, 16'd20, 0, 0, 10);
    n = 0;
    while (!(gcd_req === 1'b1 && rphase == 2) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reached_breq", rphase, 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_gcd_req", gcd_req, 1'b0);
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    run_pair("mid_after", 16'd12, 16'd8, 0, 0, 0, 16'd4, ref_cyc(0, 0, 0));

    // randomized pairs against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      logic [DW-1:0] g, x, y;
      int da, dr, db;
      g  = 16'($urandom_range(1, 50));
      x  = 16'($urandom_range(1, 1000));
      y  = 16'($urandom_range(1, 1000));
      da = int'($urandom_range(0, 3));
      dr = int'($urandom_range(0, 3));
      db = int'($urandom_range(0, 14));
      run_pair($sformatf("rnd%0d", i), g * x, g * y, da, dr, db,
               ref_gcd(g * x, g * y), ref_cyc(da, dr, db));
    end

`ifdef GCD_REQ_ZERO_BYPASS_EN
    begin
      int r0;
      r0 = rises;
      start(16'd0, 16'd9, 0, 0, 0);
      chk("byp_valid", out_valid, 1'b1);
      chk("byp_c", out_c, 16'd9);
      chk("byp_cycles", out_cycles, 4'd0);
      chk("byp_req", gcd_req, 1'b0);
      release_out();
      chk("byp_no_rise", rises - r0, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
